// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcode values, ALU-op class codes and
// the control bundle carried from ID into the ID/EX register.
package mips_ctrl_pkg;

    localparam int NB_OPCODE_PKG = 6;
    localparam int NB_ALUOP_PKG  = 2;

    localparam logic [NB_OPCODE_PKG-1:0] OP_RTYPE = 6'b000000;
    localparam logic [NB_OPCODE_PKG-1:0] OP_LW    = 6'b100011;
    localparam logic [NB_OPCODE_PKG-1:0] OP_SW    = 6'b101011;
    localparam logic [NB_OPCODE_PKG-1:0] OP_BEQ   = 6'b000100;
    localparam logic [NB_OPCODE_PKG-1:0] OP_ADDI  = 6'b001000;
    localparam logic [NB_OPCODE_PKG-1:0] OP_J     = 6'b000010;

    localparam logic [NB_ALUOP_PKG-1:0] ALU_ADD   = 2'b00;
    localparam logic [NB_ALUOP_PKG-1:0] ALU_SUB   = 2'b01;
    localparam logic [NB_ALUOP_PKG-1:0] ALU_FUNCT = 2'b10;

    // One decoded instruction's worth of control. All-zero means "do nothing",
    // which is also what a bubble or a flushed entry carries.
    typedef struct packed {
        logic                    mult_a;
        logic                    mult_b;
        logic                    reg_dst;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    branch;
        logic                    jump;
        logic                    illegal;
        logic [NB_ALUOP_PKG-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ctrl_decode.sv
// Purely combinational opcode decoder. Produces the control bundle for the
// ID/EX register and flags whether the instruction actually reads rt, which
// the load-use hazard check needs.
module id_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int NB_OPCODE = 6
) (
    input  logic [NB_OPCODE-1:0] i_opcode,
    output ctrl_t                o_ctrl,
    output logic                 o_rt_used
);

    // Opcode table; anything not listed decodes as illegal with no side effects.
    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_rt_used = 1'b0;
        case (i_opcode)
            NB_OPCODE'(OP_RTYPE): begin
                o_ctrl.mult_a    = 1'b1;
                o_ctrl.mult_b    = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
                o_rt_used        = 1'b1;
            end
            NB_OPCODE'(OP_LW): begin
                o_ctrl.mult_a     = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.alu_op     = ALU_ADD;
            end
            NB_OPCODE'(OP_SW): begin
                o_ctrl.mult_a    = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
                o_rt_used        = 1'b1;
            end
            NB_OPCODE'(OP_BEQ): begin
                o_ctrl.mult_a = 1'b1;
                o_ctrl.mult_b = 1'b1;
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALU_SUB;
                o_rt_used     = 1'b1;
            end
            NB_OPCODE'(OP_ADDI): begin
                o_ctrl.mult_a    = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
            end
            NB_OPCODE'(OP_J): begin
                o_ctrl.jump = 1'b1;
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_control_pipe.sv
// ID stage control path: decodes the IF/ID opcode into the ID/EX control
// register, detects load-use hazards against the entry already in ID/EX and
// inserts a single bubble when one occurs.
// Build option: define HAZARD_DETECT_EN to enable load-use detection and the
// saturating bubble counter; otherwise o_stall and o_hazard_cnt are tied 0.
module id_control_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int NB_OPCODE = 6,
    parameter int NB_REG    = 5,
    parameter int NB_ALUOP  = 2,
    parameter int NB_CNT    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic [NB_REG-1:0]    i_rs,
    input  logic [NB_REG-1:0]    i_rt,
    input  logic                 i_stall_ext,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic                 o_signal_control_mult_A,
    output logic                 o_signal_control_mult_B,
    output logic                 o_reg_dst,
    output logic                 o_reg_write,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_mem_to_reg,
    output logic                 o_branch,
    output logic                 o_jump,
    output logic                 o_illegal,
    output logic [NB_ALUOP-1:0]  o_alu_op,
    output logic [NB_REG-1:0]    o_rt_ex,
    output logic                 o_stall,
    output logic [NB_CNT-1:0]    o_hazard_cnt
);

    ctrl_t             w_ctrl;
    logic              w_rt_used;
    logic              w_hazard;
    logic              w_bubble;

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [NB_REG-1:0] r_rt;

    id_ctrl_decode #(
        .NB_OPCODE (NB_OPCODE)
    ) u_decode (
        .i_opcode  (i_opcode),
        .o_ctrl    (w_ctrl),
        .o_rt_used (w_rt_used)
    );

`ifdef HAZARD_DETECT_EN
    logic [NB_CNT-1:0] r_hazard_cnt;

    // Load-use hazard: the ID/EX load writes a nonzero rt that the decoding
    // instruction reads as rs, or as rt when that instruction really uses rt.
    always_comb begin
        w_hazard = r_valid && r_ctrl.mem_read && (r_rt != '0) && i_valid &&
                   ((r_rt == i_rs) || (w_rt_used && (r_rt == i_rt)));
    end

    // Bubble counter bumps once per inserted bubble and sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hazard_cnt <= '0;
        end else if (w_bubble && (r_hazard_cnt != '1)) begin
            r_hazard_cnt <= r_hazard_cnt + 1'b1;
        end
    end

    assign o_hazard_cnt = r_hazard_cnt;
`else
    logic w_unused;

    assign w_unused     = ^{i_rs, w_rt_used};
    assign w_hazard     = 1'b0;
    assign o_hazard_cnt = '0;
`endif

    // Flush and external stall both outrank the hazard, so a bubble is only
    // inserted when the ID/EX register would otherwise load this cycle.
    assign w_bubble = w_hazard && !i_flush && !i_stall_ext;
    assign o_stall  = w_bubble;

    // ID/EX register: flush clears, external stall holds, hazard inserts a
    // bubble, otherwise the fresh decode loads (a bubble when IF/ID is empty).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_rt    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_rt    <= '0;
        end else if (i_stall_ext) begin
            r_valid <= r_valid;
            r_ctrl  <= r_ctrl;
            r_rt    <= r_rt;
        end else if (w_bubble || !i_valid) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_rt    <= '0;
        end else begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_rt    <= i_rt;
        end
    end

    assign o_valid                 = r_valid;
    assign o_signal_control_mult_A = r_ctrl.mult_a;
    assign o_signal_control_mult_B = r_ctrl.mult_b;
    assign o_reg_dst               = r_ctrl.reg_dst;
    assign o_reg_write             = r_ctrl.reg_write;
    assign o_mem_read              = r_ctrl.mem_read;
    assign o_mem_write             = r_ctrl.mem_write;
    assign o_mem_to_reg            = r_ctrl.mem_to_reg;
    assign o_branch                = r_ctrl.branch;
    assign o_jump                  = r_ctrl.jump;
    assign o_illegal               = r_ctrl.illegal;
    assign o_alu_op                = NB_ALUOP'(r_ctrl.alu_op);
    assign o_rt_ex                 = r_rt;

endmodule

// File: tb/tb_id_control_pipe.sv
// Self-checking bench for id_control_pipe. The reference model stores the
// opcode sitting in ID/EX and derives the expected controls from the opcode
// table; hazards and the bubble count come from the load-use rule directly.
// Follows HAZARD_DETECT_EN the same way the design does.
module tb_id_control_pipe;

   localparam int NB_OPCODE = 6;
   localparam int NB_REG    = 5;
   localparam int NB_ALUOP  = 2;
   localparam int NB_CNT    = 2;
   localparam int CNT_MAX   = 3;

`ifdef HAZARD_DETECT_EN
   localparam bit HZ_ON = 1'b1;
`else
   localparam bit HZ_ON = 1'b0;
`endif

   localparam logic [5:0] R_OP = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   logic                 clock;
   logic                 reset;
   logic                 iValid;
   logic [NB_OPCODE-1:0] iOpcode;
   logic [NB_REG-1:0]    iRs;
   logic [NB_REG-1:0]    iRt;
   logic                 iStallExt;
   logic                 iFlush;
   logic                 oValid, oMultA, oMultB, oRegDst, oRegWrite, oMemRead;
   logic                 oMemWrite, oMemToReg, oBranch, oJump, oIllegal;
   logic [NB_ALUOP-1:0]  oAluOp;
   logic [NB_REG-1:0]    oRtEx;
   logic                 oStall;
   logic [NB_CNT-1:0]    oHazardCnt;

   int testCount = 0;
   int failCount = 0;

   // Reference model state: what ID/EX should hold, expressed as the opcode.
   bit         mValid;
   logic [5:0] mOp;
   int         mRt;
   int         mCnt;

   id_control_pipe #(
      .NB_OPCODE (NB_OPCODE),
      .NB_REG    (NB_REG),
      .NB_ALUOP  (NB_ALUOP),
      .NB_CNT    (NB_CNT)
   ) dut (
      .i_clk                   (clock),
      .i_reset                 (reset),
      .i_valid                 (iValid),
      .i_opcode                (iOpcode),
      .i_rs                    (iRs),
      .i_rt                    (iRt),
      .i_stall_ext             (iStallExt),
      .i_flush                 (iFlush),
      .o_valid                 (oValid),
      .o_signal_control_mult_A (oMultA),
      .o_signal_control_mult_B (oMultB),
      .o_reg_dst               (oRegDst),
      .o_reg_write             (oRegWrite),
      .o_mem_read              (oMemRead),
      .o_mem_write             (oMemWrite),
      .o_mem_to_reg            (oMemToReg),
      .o_branch                (oBranch),
      .o_jump                  (oJump),
      .o_illegal               (oIllegal),
      .o_alu_op                (oAluOp),
      .o_rt_ex                 (oRtEx),
      .o_stall                 (oStall),
      .o_hazard_cnt            (oHazardCnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected {A,B,reg_dst,reg_write,mem_read,mem_write,mem_to_reg,branch,jump,illegal,alu_op}
   function automatic logic [11:0] tableOf(input logic [5:0] op);
      case (op)
         R_OP:    return {10'b1111000000, 2'b10};
         LW:      return {10'b1001101000, 2'b00};
         SW:      return {10'b1000010000, 2'b00};
         BEQ:     return {10'b1100000100, 2'b01};
         ADDI:    return {10'b1001000000, 2'b00};
         JMP:     return {10'b0000000010, 2'b00};
         default: return {10'b0000000001, 2'b00};
      endcase
   endfunction

   function automatic bit readsRt(input logic [5:0] op);
      return (op == R_OP) || (op == SW) || (op == BEQ);
   endfunction

   function automatic logic [12:0] expectedBundle();
      return mValid ? {1'b1, tableOf(mOp)} : 13'd0;
   endfunction

   function automatic logic [12:0] observedBundle();
      return {oValid, oMultA, oMultB, oRegDst, oRegWrite, oMemRead, oMemWrite,
              oMemToReg, oBranch, oJump, oIllegal, oAluOp};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive IF/ID and control inputs, check the combinational
   // stall, clock, advance the model, check the registered entry.
   task automatic applyStimulus(input bit v, input logic [5:0] op, input int rs,
                                input int rt, input bit stx, input bit fl,
                                output bit stalled);
      bit hazard;
      iValid    = v;
      iOpcode   = op;
      iRs       = NB_REG'(rs);
      iRt       = NB_REG'(rt);
      iStallExt = stx;
      iFlush    = fl;
      #1;
      hazard  = HZ_ON && mValid && (mOp == LW) && (mRt != 0) && v &&
                ((mRt == rs) || (readsRt(op) && (mRt == rt)));
      stalled = hazard && !fl && !stx;
      checkOutput("stall", 32'(oStall), 32'(stalled));
      @(posedge clock);
      if (fl) begin
         mValid = 0;
         mRt    = 0;
      end else if (stx) begin
         // entry holds
      end else if (stalled) begin
         mValid = 0;
         mRt    = 0;
         if (mCnt < CNT_MAX) mCnt++;
      end else if (!v) begin
         mValid = 0;
         mRt    = 0;
      end else begin
         mValid = 1;
         mOp    = op;
         mRt    = rt;
      end
      #1;
      checkOutput("bundle", 32'(observedBundle()), 32'(expectedBundle()));
      checkOutput("rt_ex", 32'(oRtEx), 32'(mRt));
      checkOutput("hazard_cnt", 32'(oHazardCnt), 32'(mCnt));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_bundle"}, 32'(observedBundle()), 32'd0);
      checkOutput({tag, "_rt"}, 32'(oRtEx), 32'd0);
      checkOutput({tag, "_cnt"}, 32'(oHazardCnt), 32'd0);
      checkOutput({tag, "_stall"}, 32'(oStall), 32'd0);
   endtask

   function automatic logic [5:0] randomOpcode();
      logic [5:0] ops [7];
      ops = '{R_OP, LW, SW, BEQ, ADDI, JMP, BAD};
      if ($urandom_range(9) == 0) return 6'($urandom);
      return ops[$urandom_range(6)];
   endfunction

   initial begin
      bit         st;
      logic [5:0] dirOps [7];
      logic [5:0] op;
      int         rs, rt;
      bit         v, stx, fl;

      dirOps = '{R_OP, LW, SW, BEQ, ADDI, JMP, BAD};
      mValid = 0; mOp = '0; mRt = 0; mCnt = 0;
      reset = 1'b1; iValid = 0; iOpcode = '0; iRs = '0; iRt = '0;
      iStallExt = 0; iFlush = 0;
      #12;
      checkAllZero("reset");
      reset = 1'b0;
      #4;

      // Every opcode class once, including an illegal one.
      foreach (dirOps[k]) applyStimulus(1, dirOps[k], 1, 2, 0, 0, st);

      // Load-use on rs: one bubble, then the re-presented R loads.
      applyStimulus(1, LW, 1, 5, 0, 0, st);
      applyStimulus(1, R_OP, 5, 3, 0, 0, st);
      applyStimulus(1, R_OP, 5, 3, 0, 0, st);

      // Load to $0 never stalls.
      applyStimulus(1, LW, 1, 0, 0, 0, st);
      applyStimulus(1, R_OP, 0, 0, 0, 0, st);

      // External stall freezes a load for three cycles, then flush+stall clears.
      applyStimulus(1, LW, 2, 7, 0, 0, st);
      for (int i = 0; i < 3; i++) applyStimulus(1, ADDI, 4, 4, 1, 0, st);
      applyStimulus(1, ADDI, 4, 4, 1, 1, st);

      // Five load-use pairs (rt and rs variants) drive the counter to saturation.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, LW, 0, 6, 0, 0, st);
         if (i % 2 == 0) applyStimulus(1, SW, 1, 6, 0, 0, st);
         else            applyStimulus(1, BEQ, 6, 1, 0, 0, st);
         if (st) applyStimulus(1, ADDI, 1, 1, 0, 0, st);
      end

      // Reset in the middle of a pending load-use stall.
      applyStimulus(1, LW, 1, 3, 0, 0, st);
      iValid = 1; iOpcode = R_OP; iRs = 5'd3; iRt = 5'd3;
      #2;
      reset = 1'b1;
      #1;
      checkAllZero("midreset");
      mValid = 0; mRt = 0; mCnt = 0;
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(1, R_OP, 3, 3, 0, 0, st);

      // Randomized traffic with small register indices to provoke hazards;
      // a stalled instruction is re-presented, as IF/ID would.
      op = R_OP; rs = 0; rt = 0; st = 0;
      for (int n = 0; n < 400; n++) begin
         if (!st) begin
            op = randomOpcode();
            rs = int'($urandom_range(3));
            rt = int'($urandom_range(3));
            v  = ($urandom_range(9) != 0);
         end
         stx = ($urandom_range(6) == 0);
         fl  = ($urandom_range(9) == 0);
         applyStimulus(v, op, rs, rt, stx, fl, st);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/id_control_pipe.md
ID_CONTROL_PIPE -- requirements
Module: id_control_pipe

Interface
REQ-001 SHALL have parameter NB_OPCODE, default 6, opcode field width.
REQ-002 SHALL have parameter NB_REG, default 5, register-index width.
REQ-003 SHALL have parameter NB_ALUOP, default 2, ALU-op code width.
REQ-004 SHALL have parameter NB_CNT, default 8, hazard-counter width.
REQ-005 i_clk  input  1  single clock; all state on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_valid  input  1  IF/ID holds a valid instruction.
REQ-008 i_opcode  input  NB_OPCODE  instruction opcode.
REQ-009 i_rs, i_rt  input  NB_REG each  source register indices.
REQ-010 i_stall_ext  input  1  downstream stall; hold ID/EX contents.
REQ-011 i_flush  input  1  branch/jump flush; clear ID/EX entry.
REQ-012 o_valid  output  1  ID/EX entry valid.
REQ-013 o_signal_control_mult_A, o_signal_control_mult_B  output  1 each  ALU operand mux selects (A: 1=rs; B: 1=rt, 0=immediate).
REQ-014 o_reg_dst, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch, o_jump, o_illegal  output  1 each  registered control bundle.
REQ-015 o_alu_op  output  NB_ALUOP  ALU op class (00 add, 01 sub, 10 funct-decoded).
REQ-016 o_rt_ex  output  NB_REG  registered rt of ID/EX entry.
REQ-017 o_stall  output  1  combinational load-use stall request to PC and IF/ID.
REQ-018 o_hazard_cnt  output  NB_CNT  saturating count of inserted bubbles (macro-gated).

Function
REQ-019 Decode (A,B,reg_dst,reg_write,mem_read,mem_write,mem_to_reg,branch,jump,alu_op): R 000000 ->1,1,1,1,0,0,0,0,0,10; LW 100011 ->1,0,0,1,1,0,1,0,0,00; SW 101011 ->1,0,0,0,0,1,0,0,0,00; BEQ 000100 ->1,1,0,0,0,0,0,1,0,01; ADDI 001000 ->1,0,0,1,0,0,0,0,0,00; J 000010 ->0,0,0,0,0,0,0,0,1,00.
REQ-020 Any other opcode SHALL load an entry with o_valid=1, o_illegal=1, all other controls 0.
REQ-021 Decoded bundle SHALL appear on outputs one cycle after capture (latency 1); o_stall has latency 0.
REQ-022 Hazard SHALL be o_valid & o_mem_read & (o_rt_ex!=0) & i_valid & (o_rt_ex==i_rs | (rt_used & o_rt_ex==i_rt)), rt_used true for R, SW, BEQ.
REQ-023 o_stall SHALL equal hazard & ~i_flush & ~i_stall_ext.
REQ-024 Per-edge priority: i_flush > i_stall_ext > hazard > load.
REQ-025 i_flush SHALL clear the entry (o_valid=0, all controls 0), regardless of i_stall_ext.
REQ-026 i_stall_ext (no flush) SHALL hold every registered output unchanged.
REQ-027 Hazard (no flush/ext stall) SHALL load a bubble (o_valid=0, controls 0, o_rt_ex=0); stall lasts exactly one cycle per load-use pair.
REQ-028 Otherwise the entry SHALL load the decode of i_opcode with o_valid=i_valid; i_valid=0 loads a bubble.
REQ-029 o_rt_ex SHALL load i_rt whenever a valid entry loads.

Reset
REQ-030 i_reset SHALL asynchronously force o_valid, all control outputs, o_alu_op, o_rt_ex and o_hazard_cnt to 0; o_stall then reads 0.
REQ-031 Reset mid-stall SHALL discard the held entry; first post-reset edge loads normally.

Configuration
REQ-032 With HAZARD_DETECT_EN defined: REQ-022..REQ-027 hazard logic and o_hazard_cnt active; counter increments per inserted bubble, saturates at 2^NB_CNT-1.
REQ-033 Without HAZARD_DETECT_EN: o_stall tied 0, no hazard bubbles, o_hazard_cnt tied 0; flush/ext-stall behaviour unchanged.

Structure
REQ-034 Opcode localparams, ALU-op codes and control-bundle field widths SHALL live in shared package mips_ctrl_pkg.
REQ-035 Pure combinational decode SHALL be sub-module id_ctrl_decode (opcode in, bundle and rt_used out); id_control_pipe holds the ID/EX register, hazard logic and counter.

Verification
REQ-036 Reset asserted between edges -> all outputs 0 immediately, without a clock edge.
REQ-037 Drive R, LW, SW, BEQ, ADDI, J, 111111 with i_valid=1 -> next cycle bundle matches REQ-019; 111111 gives o_illegal=1, others 0.
REQ-038 LW rt=5, then R rs=5 -> o_stall=1 one cycle, bubble in ID/EX, R entry loads next cycle; o_hazard_cnt=1.
REQ-039 LW rt=0, then R rs=0 -> o_stall stays 0, no bubble.
REQ-040 i_stall_ext=1 for 3 cycles with LW held -> outputs frozen; i_flush=1 with i_stall_ext=1 -> o_valid=0 next cycle.
REQ-041 NB_CNT=2, 5 load-use pairs -> o_hazard_cnt saturates at 3; without HAZARD_DETECT_EN same stimulus -> o_stall=0, count 0.
